// File: rtl/tcp_port_encap_if.sv
// IP header plus 8-bit AXI-Stream payload bundle shared by the IP TX path stages.
interface ip_intf;
  logic [47:0] eth_dest_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_type;
  logic        ip_hdr_valid;
  logic        ip_hdr_ready;
  logic [3:0]  ip_version;
  logic [3:0]  ip_ihl;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] ip_length;
  logic [15:0] ip_identification;
  logic [2:0]  ip_flags;
  logic [12:0] ip_fragment_offset;
  logic [7:0]  ip_ttl;
  logic [7:0]  ip_protocol;
  logic [15:0] ip_header_checksum;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [7:0]  ip_payload_axis_tdata;
  logic        ip_payload_axis_tvalid;
  logic        ip_payload_axis_tready;
  logic        ip_payload_axis_tlast;

  modport MASTER (
    output eth_dest_mac, eth_src_mac, eth_type, ip_hdr_valid,
    output ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length, ip_identification,
    output ip_flags, ip_fragment_offset, ip_ttl, ip_protocol, ip_header_checksum,
    output ip_source_ip, ip_dest_ip,
    output ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
    input  ip_hdr_ready, ip_payload_axis_tready
  );

  modport SLAVE (
    input  ip_hdr_valid,
    input  ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length, ip_identification,
    input  ip_flags, ip_fragment_offset, ip_ttl, ip_protocol, ip_header_checksum,
    input  ip_source_ip, ip_dest_ip,
    input  ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
    output ip_hdr_ready, ip_payload_axis_tready
  );
endinterface

// File: rtl/tcp_port_encap.sv
// Prepends the big-endian {src_port, dest_port} field to each outgoing IP payload
// and forwards the IP header through a one-entry register, optionally growing ip_length by 4.
module tcp_port_encap #(
  parameter bit ADJUST_LENGTH = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ip_intf.SLAVE       s_ip,
  ip_intf.MASTER      m_ip,
  input  logic [15:0] i_tcp_src,
  input  logic [15:0] i_tcp_dest,
  input  logic        i_tcp_valid,
  output logic        o_tcp_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PORTS = 2'd1,
    PASS  = 2'd2
  } state_t;

  localparam int HDR_W = 160;

  logic [HDR_W-1:0] hdr_in;
  logic [HDR_W-1:0] hdr_r;
  logic             hdr_full_r;
  logic [15:0]      len_in;

  state_t      state_r;
  state_t      state_next;
  logic [1:0]  cnt_r;
  logic [31:0] ports_r;
  logic        live_r;
  logic        port_take;

  // Length adjustment is applied before the register so the header output stays registered.
  always_comb begin
    len_in = s_ip.ip_length;
    if (ADJUST_LENGTH) begin
      len_in = s_ip.ip_length + 16'd4;
    end else begin
      len_in = s_ip.ip_length;
    end
  end

  assign hdr_in = {s_ip.ip_version, s_ip.ip_ihl, s_ip.ip_dscp, s_ip.ip_ecn, len_in,
                   s_ip.ip_identification, s_ip.ip_flags, s_ip.ip_fragment_offset,
                   s_ip.ip_ttl, s_ip.ip_protocol, s_ip.ip_header_checksum,
                   s_ip.ip_source_ip, s_ip.ip_dest_ip};

  assign s_ip.ip_hdr_ready = !hdr_full_r || m_ip.ip_hdr_ready;

  // Header holding register, refilled in the same cycle it drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hdr_full_r <= 1'b0;
      hdr_r      <= '0;
    end else if (s_ip.ip_hdr_valid && s_ip.ip_hdr_ready) begin
      hdr_full_r <= 1'b1;
      hdr_r      <= hdr_in;
    end else if (m_ip.ip_hdr_ready) begin
      hdr_full_r <= 1'b0;
    end
  end

  assign m_ip.ip_hdr_valid = hdr_full_r;
  assign {m_ip.ip_version, m_ip.ip_ihl, m_ip.ip_dscp, m_ip.ip_ecn, m_ip.ip_length,
          m_ip.ip_identification, m_ip.ip_flags, m_ip.ip_fragment_offset,
          m_ip.ip_ttl, m_ip.ip_protocol, m_ip.ip_header_checksum,
          m_ip.ip_source_ip, m_ip.ip_dest_ip} = hdr_r;
  assign m_ip.eth_dest_mac = 48'h0;
  assign m_ip.eth_src_mac  = 48'h0;
  assign m_ip.eth_type     = 16'h0;

  // live_r keeps o_tcp_ready low while reset is held and for the first cycle after it.
  assign port_take = (state_r == IDLE) && live_r && i_tcp_valid;

  // Payload FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Port latch and byte counter; the counter only moves on an output handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      live_r  <= 1'b0;
      cnt_r   <= 2'd0;
      ports_r <= 32'h0;
    end else begin
      live_r <= 1'b1;
      if (port_take) begin
        ports_r <= {i_tcp_src, i_tcp_dest};
        cnt_r   <= 2'd0;
      end else if ((state_r == PORTS) && m_ip.ip_payload_axis_tready) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end
  end

  // Next state and payload steering.
  always_comb begin
    state_next                  = state_r;
    o_tcp_ready                 = 1'b0;
    s_ip.ip_payload_axis_tready = 1'b0;
    m_ip.ip_payload_axis_tvalid = 1'b0;
    m_ip.ip_payload_axis_tdata  = 8'h00;
    m_ip.ip_payload_axis_tlast  = 1'b0;
    case (state_r)
      IDLE: begin
        o_tcp_ready = live_r;
        if (port_take) begin
          state_next = PORTS;
        end else begin
          state_next = IDLE;
        end
      end
      PORTS: begin
        m_ip.ip_payload_axis_tvalid = 1'b1;
        case (cnt_r)
          2'd0:    m_ip.ip_payload_axis_tdata = ports_r[31:24];
          2'd1:    m_ip.ip_payload_axis_tdata = ports_r[23:16];
          2'd2:    m_ip.ip_payload_axis_tdata = ports_r[15:8];
          default: m_ip.ip_payload_axis_tdata = ports_r[7:0];
        endcase
        if (m_ip.ip_payload_axis_tready && (cnt_r == 2'd3)) begin
          state_next = PASS;
        end else begin
          state_next = PORTS;
        end
      end
      PASS: begin
        m_ip.ip_payload_axis_tvalid = s_ip.ip_payload_axis_tvalid;
        m_ip.ip_payload_axis_tdata  = s_ip.ip_payload_axis_tdata;
        m_ip.ip_payload_axis_tlast  = s_ip.ip_payload_axis_tlast;
        s_ip.ip_payload_axis_tready = m_ip.ip_payload_axis_tready;
        if (s_ip.ip_payload_axis_tvalid && m_ip.ip_payload_axis_tready &&
            s_ip.ip_payload_axis_tlast) begin
          state_next = IDLE;
        end else begin
          state_next = PASS;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tcp_port_encap.sv
// Randomized scoreboard bench for tcp_port_encap: drivers queue expectations, monitors compare.
module tb_tcp_port_encap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tcp_src = 16'h0;
  logic [15:0] tcp_dest = 16'h0;
  logic        tcp_valid = 1'b0;
  logic        tcp_ready;
  logic        tcp_ready0;

  ip_intf s_if ();
  ip_intf m_if ();
  ip_intf s0_if ();
  ip_intf m0_if ();

  logic [159:0] s_hdr = '0;
  logic         s_hdr_valid = 1'b0;
  wire  [159:0] m_hdr = {m_if.ip_version, m_if.ip_ihl, m_if.ip_dscp, m_if.ip_ecn, m_if.ip_length,
                         m_if.ip_identification, m_if.ip_flags, m_if.ip_fragment_offset, m_if.ip_ttl,
                         m_if.ip_protocol, m_if.ip_header_checksum, m_if.ip_source_ip, m_if.ip_dest_ip};
  wire  [159:0] m0_hdr = {m0_if.ip_version, m0_if.ip_ihl, m0_if.ip_dscp, m0_if.ip_ecn, m0_if.ip_length,
                          m0_if.ip_identification, m0_if.ip_flags, m0_if.ip_fragment_offset, m0_if.ip_ttl,
                          m0_if.ip_protocol, m0_if.ip_header_checksum, m0_if.ip_source_ip, m0_if.ip_dest_ip};

  assign {s_if.ip_version, s_if.ip_ihl, s_if.ip_dscp, s_if.ip_ecn, s_if.ip_length,
          s_if.ip_identification, s_if.ip_flags, s_if.ip_fragment_offset, s_if.ip_ttl,
          s_if.ip_protocol, s_if.ip_header_checksum, s_if.ip_source_ip, s_if.ip_dest_ip} = s_hdr;
  assign {s0_if.ip_version, s0_if.ip_ihl, s0_if.ip_dscp, s0_if.ip_ecn, s0_if.ip_length,
          s0_if.ip_identification, s0_if.ip_flags, s0_if.ip_fragment_offset, s0_if.ip_ttl,
          s0_if.ip_protocol, s0_if.ip_header_checksum, s0_if.ip_source_ip, s0_if.ip_dest_ip} = s_hdr;
  assign s_if.ip_hdr_valid  = s_hdr_valid;
  assign s0_if.ip_hdr_valid = s_hdr_valid;
  assign s_if.eth_dest_mac  = 48'h0;
  assign s_if.eth_src_mac   = 48'h0;
  assign s_if.eth_type      = 16'h0;
  assign s0_if.eth_dest_mac = 48'h0;
  assign s0_if.eth_src_mac  = 48'h0;
  assign s0_if.eth_type     = 16'h0;
  assign s0_if.ip_payload_axis_tdata  = 8'h00;
  assign s0_if.ip_payload_axis_tvalid = 1'b0;
  assign s0_if.ip_payload_axis_tlast  = 1'b0;
  assign m0_if.ip_hdr_ready           = m_if.ip_hdr_ready;
  assign m0_if.ip_payload_axis_tready = 1'b1;

  tcp_port_encap #(.ADJUST_LENGTH(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .s_ip(s_if), .m_ip(m_if),
    .i_tcp_src(tcp_src), .i_tcp_dest(tcp_dest), .i_tcp_valid(tcp_valid), .o_tcp_ready(tcp_ready)
  );

  tcp_port_encap #(.ADJUST_LENGTH(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .s_ip(s0_if), .m_ip(m0_if),
    .i_tcp_src(16'h0), .i_tcp_dest(16'h0), .i_tcp_valid(1'b0), .o_tcp_ready(tcp_ready0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rmode = 0;   // payload tready: 0 always, 1 random, 2 stalled
  int hmode = 0;   // header ready, same encoding
  bit gaps = 1'b0;
  int ports_taken = 0;
  int pkts_done = 0;

  logic [15:0]  psrc_q[$];
  logic [15:0]  pdst_q[$];
  logic [8:0]   pay_q[$];
  logic [8:0]   exp_pay[$];
  logic [159:0] hdr_q[$];
  logic [159:0] exp_a[$];
  logic [159:0] exp_b[$];

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within bound, expected one", name);
  endtask

  // Reference: four port bytes (big-endian src then dest), then the payload unchanged.
  task automatic add_pkt(input logic [15:0] src, input logic [15:0] dst, input int len,
                         input logic [23:0] fixed, input bit use_fixed);
    logic [7:0] b;
    psrc_q.push_back(src);
    pdst_q.push_back(dst);
    exp_pay.push_back({1'b0, src[15:8]});
    exp_pay.push_back({1'b0, src[7:0]});
    exp_pay.push_back({1'b0, dst[15:8]});
    exp_pay.push_back({1'b0, dst[7:0]});
    for (int j = 0; j < len; j++) begin
      b = use_fixed ? fixed[23 - 8*j -: 8] : 8'($urandom);
      pay_q.push_back({(j == len - 1), b});
      exp_pay.push_back({(j == len - 1), b});
    end
  endtask

  task automatic add_hdr(input logic [159:0] h);
    logic [159:0] a;
    a = h;
    a[143:128] = 16'((32'(h[143:128]) + 32'd4) % 32'd65536);
    hdr_q.push_back(h);
    exp_a.push_back(a);
    exp_b.push_back(h);
  endtask

  task automatic drive_ports(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      tcp_valid = 1'b1;
      tcp_src   = psrc_q.pop_front();
      tcp_dest  = pdst_q.pop_front();
      #1;
      while (!tcp_ready && t < 2000) begin
        @(negedge clk); #1; t++;
      end
      if (t >= 2000) timeout("port_handshake");
      else check("pair_after_tlast", 288'(ports_taken), 288'(pkts_done));
      ports_taken++;
      @(posedge clk);
    end
    @(negedge clk);
    tcp_valid = 1'b0;
  endtask

  task automatic drive_payload();
    logic [8:0] v;
    while (pay_q.size() > 0) begin
      int t = 0;
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_if.ip_payload_axis_tvalid = 1'b0;
        continue;
      end
      v = pay_q.pop_front();
      s_if.ip_payload_axis_tvalid = 1'b1;
      s_if.ip_payload_axis_tdata  = v[7:0];
      s_if.ip_payload_axis_tlast  = v[8];
      #1;
      while (!s_if.ip_payload_axis_tready && t < 2000) begin
        @(negedge clk); #1; t++;
      end
      if (t >= 2000) timeout("payload_handshake");
      @(posedge clk);
    end
    @(negedge clk);
    s_if.ip_payload_axis_tvalid = 1'b0;
    s_if.ip_payload_axis_tlast  = 1'b0;
  endtask

  task automatic drive_hdrs();
    while (hdr_q.size() > 0) begin
      int t = 0;
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_hdr_valid = 1'b0;
        continue;
      end
      s_hdr = hdr_q.pop_front();
      s_hdr_valid = 1'b1;
      #1;
      while (!s_if.ip_hdr_ready && t < 2000) begin
        @(negedge clk); #1; t++;
      end
      if (t >= 2000) timeout("hdr_handshake");
      @(posedge clk);
    end
    @(negedge clk);
    s_hdr_valid = 1'b0;
  endtask

  task automatic run_all();
    int n;
    n = psrc_q.size();
    fork
      drive_ports(n);
      drive_payload();
      drive_hdrs();
    join
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_pay.size() > 0 || exp_a.size() > 0) && t < 1000) begin
      @(negedge clk); t++;
    end
    check("drain_payload", 288'(exp_pay.size()), 288'd0);
    check("drain_header", 288'(exp_a.size()), 288'd0);
  endtask

  // Downstream ready generation.
  initial begin
    m_if.ip_hdr_ready = 1'b1;
    m_if.ip_payload_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (rmode == 0) m_if.ip_payload_axis_tready = 1'b1;
      else if (rmode == 1) m_if.ip_payload_axis_tready = 1'($urandom_range(0, 1));
      else m_if.ip_payload_axis_tready = 1'b0;
      if (hmode == 0) m_if.ip_hdr_ready = 1'b1;
      else if (hmode == 1) m_if.ip_hdr_ready = 1'($urandom_range(0, 1));
      else m_if.ip_hdr_ready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  logic         hold_p = 1'b0;
  logic [8:0]   held_p;
  logic         hold_h = 1'b0;
  logic [159:0] held_h;
  initial begin
    logic [8:0]   e;
    logic [159:0] a;
    logic [159:0] b;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        hold_p = 1'b0;
        hold_h = 1'b0;
      end else begin
        if (hold_p)
          check("payload_stable", {m_if.ip_payload_axis_tvalid, m_if.ip_payload_axis_tlast, m_if.ip_payload_axis_tdata},
                {1'b1, held_p});
        if (m_if.ip_payload_axis_tvalid && m_if.ip_payload_axis_tready) begin
          if (exp_pay.size() == 0) begin
            checks++; errors++;
            $display("FAIL payload_extra: got byte %0h, expected no beat", m_if.ip_payload_axis_tdata);
          end else begin
            e = exp_pay.pop_front();
            check("payload_beat", {m_if.ip_payload_axis_tlast, m_if.ip_payload_axis_tdata}, e);
          end
          if (m_if.ip_payload_axis_tlast) pkts_done++;
        end
        hold_p = m_if.ip_payload_axis_tvalid && !m_if.ip_payload_axis_tready;
        held_p = {m_if.ip_payload_axis_tlast, m_if.ip_payload_axis_tdata};

        if (hold_h) check("hdr_stable", {m_if.ip_hdr_valid, m_hdr}, {1'b1, held_h});
        if (m_if.ip_hdr_valid && m_if.ip_hdr_ready) begin
          if (exp_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL hdr_extra: got header %0h, expected none", m_hdr);
          end else begin
            a = exp_a.pop_front();
            b = exp_b.pop_front();
            check("hdr_adjusted", {m_if.eth_dest_mac, m_if.eth_src_mac, m_if.eth_type, m_hdr}, {112'h0, a});
            check("hdr_unadjusted", {m0_if.ip_hdr_valid, m0_hdr}, {1'b1, b});
          end
        end
        hold_h = m_if.ip_hdr_valid && !m_if.ip_hdr_ready;
        held_h = m_hdr;
      end
    end
  end

  initial begin
    logic [159:0] h;
    logic [7:0]   d0, d1;
    s_if.ip_payload_axis_tvalid = 1'b0;
    s_if.ip_payload_axis_tdata  = 8'h00;
    s_if.ip_payload_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tcp_ready", tcp_ready, 0);
    check("rst_tvalid", m_if.ip_payload_axis_tvalid, 0);
    check("rst_hdr_valid", m_if.ip_hdr_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_tcp_ready", tcp_ready, 1);

    // Basic packet and header with length 0x0020.
    add_pkt(16'h1234, 16'h0050, 3, 24'hAABBCC, 1'b1);
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    h[143:128] = 16'h0020;
    add_hdr(h);
    run_all();
    drain();

    // Same packet under 50% downstream back-pressure.
    rmode = 1;
    add_pkt(16'h1234, 16'h0050, 3, 24'hAABBCC, 1'b1);
    run_all();
    drain();

    // Back-to-back packets with the second pair held early.
    rmode = 0;
    add_pkt(16'h0001, 16'h0002, $urandom_range(1, 6), 24'h0, 1'b0);
    add_pkt(16'h0003, 16'h0004, $urandom_range(1, 6), 24'h0, 1'b0);
    run_all();
    drain();

    // Randomized traffic on every channel.
    rmode = 1; hmode = 1; gaps = 1'b1;
    for (int i = 0; i < 20; i++) begin
      add_pkt(16'($urandom), 16'($urandom), $urandom_range(1, 8), 24'h0, 1'b0);
      add_hdr({$urandom, $urandom, $urandom, $urandom, $urandom});
    end
    run_all();
    drain();

    // Wrapping length while the header output is stalled.
    rmode = 0; hmode = 2; gaps = 1'b0;
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    h[143:128] = 16'hFFFE;
    add_hdr(h);
    drive_hdrs();
    repeat (4) @(negedge clk);
    hmode = 0;
    drain();

    // Reset in the middle of the payload.
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    psrc_q.push_back(16'hABCD);
    pdst_q.push_back(16'h1111);
    exp_pay.push_back({1'b0, 8'hAB});
    exp_pay.push_back({1'b0, 8'hCD});
    exp_pay.push_back({1'b0, 8'h11});
    exp_pay.push_back({1'b0, 8'h11});
    pay_q.push_back({1'b0, d0});
    pay_q.push_back({1'b0, d1});
    exp_pay.push_back({1'b0, d0});
    exp_pay.push_back({1'b0, d1});
    fork
      drive_ports(1);
      drive_payload();
    join
    rmode = 2;
    @(negedge clk);
    s_if.ip_payload_axis_tvalid = 1'b1;
    s_if.ip_payload_axis_tdata  = 8'($urandom);
    s_if.ip_payload_axis_tlast  = 1'b0;
    #3;
    check("pass_tvalid", m_if.ip_payload_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    check("midrst_tvalid", m_if.ip_payload_axis_tvalid, 0);
    check("midrst_tcp_ready", tcp_ready, 0);
    check("midrst_s_tready", s_if.ip_payload_axis_tready, 0);
    repeat (2) @(negedge clk);
    s_if.ip_payload_axis_tvalid = 1'b0;
    rmode = 0;
    rst = 1'b0;
    check("midrst_flush", 288'(exp_pay.size()), 288'd0);
    ports_taken = pkts_done;
    repeat (2) @(negedge clk);
    add_pkt(16'h5555, 16'h6666, 4, 24'h0, 1'b0);
    run_all();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
